// File: rtl/count_value_reader.sv
// count_value_reader: value-method caller that samples a 4-bit producer counter every PERIOD+2 cycles and unwraps it to EXT_W bits.
// Latency: RV captured in REQ cycle N shows on ext_count/last_sample after the edge ending cycle N+1; sample_valid pulses in cycle N+1.
// Backpressure: REQ holds with EN = RDY until the producer is ready. Optional delta checking under COUNT_VALUE_READER_CHECK_EN.
module count_value_reader #(
    parameter int PERIOD     = 12000000,
    parameter int PRESCALE_W = 24,
    parameter int EXT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             count_value_RDY,
    output logic             count_value_EN,
    input  logic [3:0]       count_value_RV,
    output logic [EXT_W-1:0] ext_count,
    output logic             sample_valid,
    output logic [3:0]       last_sample,
    output logic [4:0]       led,
    output logic             err
);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        REQ    = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [PRESCALE_W-1:0] RELOAD = PRESCALE_W'(PERIOD - 1);

    state_t                state;
    state_t                stateNext;
    logic [PRESCALE_W-1:0] prescaler;
    logic                  first;
    logic [3:0]            sample;
    logic [3:0]            delta;

    // Modular difference is the true advance whenever the producer moved fewer than 16 steps.
    assign delta = sample - last_sample;

    always_comb begin
        stateNext      = state;
        count_value_EN = 1'b0;
        sample_valid   = 1'b0;
        case (state)
            WAIT: begin
                if (prescaler == '0) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                count_value_EN = count_value_RDY & RST_N;
                if (count_value_RDY) begin
                    stateNext = UPDATE;
                end
            end
            UPDATE: begin
                sample_valid = RST_N;
                stateNext    = WAIT;
            end
            default: begin
                stateNext = WAIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= WAIT;
            prescaler   <= RELOAD;
            first       <= 1'b1;
            sample      <= '0;
            ext_count   <= '0;
            last_sample <= '0;
        end else begin
            state <= stateNext;
            case (state)
                WAIT: begin
                    if (prescaler != '0) begin
                        prescaler <= prescaler - PRESCALE_W'(1);
                    end
                end
                REQ: begin
                    if (count_value_RDY) begin
                        sample <= count_value_RV;
                    end
                end
                UPDATE: begin
                    if (first) begin
                        ext_count <= {{(EXT_W-4){1'b0}}, sample};
                        first     <= 1'b0;
                    end else begin
                        ext_count <= ext_count + EXT_W'(delta);
                    end
                    last_sample <= sample;
                    prescaler   <= RELOAD;
                end
                default: begin
                    prescaler <= RELOAD;
                end
            endcase
        end
    end

`ifdef COUNT_VALUE_READER_CHECK_EN
    // A +1/cycle producer advances PERIOD+2 plus one per stalled REQ cycle between captures.
    localparam logic [3:0] BASE_ADVANCE = 4'((PERIOD + 2) % 16);

    logic [3:0] stall;
    logic [3:0] expectedDelta;
    logic       errReg;

    assign expectedDelta = BASE_ADVANCE + stall;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall  <= '0;
            errReg <= 1'b0;
        end else begin
            if (state == REQ && !count_value_RDY) begin
                stall <= stall + 4'd1;
            end else if (state == UPDATE) begin
                stall <= '0;
            end
            if (state == UPDATE && !first && delta != expectedDelta) begin
                errReg <= 1'b1;
            end
        end
    end

    assign err = errReg;
`else
    assign err = 1'b0;
`endif

    assign led = {err, ext_count[EXT_W-1 -: 4]};

endmodule

// File: tb/tb_count_value_reader.sv
// Randomized bench for count_value_reader: a capture-timing/unwrap reference model feeds a scoreboard checked by an independent monitor.
module tb_count_value_reader;

    localparam int PERIOD = 6;
    localparam int EXT_W  = 16;
    localparam int NCYC   = 20000;

    logic             CLK;
    logic             RST_N;
    logic             count_value_RDY;
    logic             count_value_EN;
    logic [3:0]       count_value_RV;
    logic [EXT_W-1:0] ext_count;
    logic             sample_valid;
    logic [3:0]       last_sample;
    logic [4:0]       led;
    logic             err;

    count_value_reader #(
        .PERIOD    (PERIOD),
        .PRESCALE_W(24),
        .EXT_W     (EXT_W)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .count_value_RDY(count_value_RDY),
        .count_value_EN (count_value_EN),
        .count_value_RV (count_value_RV),
        .ext_count      (ext_count),
        .sample_valid   (sample_valid),
        .last_sample    (last_sample),
        .led            (led),
        .err            (err)
    );

    typedef struct packed {
        logic en;
        logic sv;
        logic zero;
    } cyc_t;

    typedef struct packed {
        logic [15:0] ext;
        logic [3:0]  last;
        logic        err;
    } upd_t;

    cyc_t cycQ[$];
    upd_t updQ[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Stimulus and reference model: a capture happens at the first ready cycle at or after
    // reqStart; the next window opens PERIOD+2 cycles after each capture.
    initial begin
        int   reqStart;
        int   cnt;
        int   holdRst;
        int   capRv;
        int   capStall;
        int   mExt;
        int   mLast;
        int   dlt;
        bit   mFirst;
        bit   mErr;
        bit   pend;
        bit   prevRstLow;
        bit   forceReq;
        bit   skip;
        cyc_t rec;
        upd_t u;

        RST_N = 1'b0;
        count_value_RDY = 1'b0;
        count_value_RV = 4'd0;
        reqStart = 0; cnt = 0; holdRst = 0; capRv = 0; capStall = 0;
        mExt = 0; mLast = 0; mFirst = 1'b1; mErr = 1'b0; pend = 1'b0;
        prevRstLow = 1'b1; forceReq = 1'b0;

        for (int t = 0; t < NCYC; t++) begin
            @(posedge CLK);
            #1;
            if (t == 5000) forceReq = 1'b1;

            if (t < 3) begin
                RST_N = 1'b0;
            end else if (t < 200) begin
                RST_N = 1'b1;
            end else if (holdRst > 0) begin
                RST_N = 1'b0;
                holdRst--;
            end else if (forceReq && t >= reqStart && !pend) begin
                RST_N = 1'b0;
                forceReq = 1'b0;
            end else if ($urandom_range(0, 799) == 0) begin
                RST_N = 1'b0;
                holdRst = $urandom_range(0, 2);
            end else begin
                RST_N = 1'b1;
            end

            if (t < 200) count_value_RDY = 1'b1;
            else if ((t / 2000) % 2 == 1) count_value_RDY = ($urandom_range(0, 1) == 1);
            else count_value_RDY = ($urandom_range(0, 3) != 0);

            skip = (t >= 200) && ($urandom_range(0, 149) == 0);
            if (!RST_N) begin
                cnt = 0;
                count_value_RV = 4'd0;
            end else begin
                count_value_RV = 4'(cnt % 16);
                cnt = cnt + 1 + int'(skip);
            end

            rec.en = 1'b0;
            rec.sv = 1'b0;
            rec.zero = prevRstLow;
            if (!RST_N) begin
                reqStart = t + 1 + PERIOD;
                pend = 1'b0;
                mFirst = 1'b1;
                mErr = 1'b0;
                mExt = 0;
                mLast = 0;
            end else if (pend) begin
                dlt = (capRv - mLast + 16) % 16;
                if (mFirst) begin
                    mExt = capRv;
                    mFirst = 1'b0;
                end else begin
                    mExt = (mExt + dlt) % 65536;
`ifdef COUNT_VALUE_READER_CHECK_EN
                    if (dlt != (PERIOD + 2 + capStall) % 16) mErr = 1'b1;
`endif
                end
                mLast = capRv;
                pend = 1'b0;
                rec.sv = 1'b1;
                u.ext = 16'(mExt);
                u.last = 4'(mLast);
                u.err = mErr;
                updQ.push_back(u);
            end else if (t >= reqStart && count_value_RDY) begin
                rec.en = 1'b1;
                pend = 1'b1;
                capRv = int'(count_value_RV);
                capStall = t - reqStart;
                reqStart = t + PERIOD + 2;
            end
            prevRstLow = !RST_N;
            cycQ.push_back(rec);
        end

        repeat (3) @(posedge CLK);
        #1;
        chk("queues_drained", cycQ.size() + updQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: checks handshake/pulse timing every cycle and register contents the cycle after each pulse.
    initial begin
        cyc_t r;
        upd_t e;
        bit   pendChk;
        pendChk = 1'b0;
        e = '0;
        forever begin
            @(negedge CLK);
            if (pendChk) begin
                chk("ext_count", int'(ext_count), int'(e.ext));
                chk("last_sample", int'(last_sample), int'(e.last));
                chk("err", int'(err), int'(e.err));
                chk("led", int'(led), int'({e.err, e.ext[15:12]}));
                pendChk = 1'b0;
            end
            if (cycQ.size() != 0) begin
                r = cycQ.pop_front();
                chk("count_value_EN", int'(count_value_EN), int'(r.en));
                chk("sample_valid", int'(sample_valid), int'(r.sv));
                if (r.zero) begin
                    chk("reset_ext_count", int'(ext_count), 0);
                    chk("reset_last_sample", int'(last_sample), 0);
                    chk("reset_err", int'(err), 0);
                    chk("reset_led", int'(led), 0);
                end
                if (sample_valid) begin
                    chk("expected_update_available", int'(updQ.size() != 0), 1);
                    if (updQ.size() != 0) begin
                        e = updQ.pop_front();
                        pendChk = 1'b1;
                    end
                end
            end
        end
    end

endmodule
